// File: rtl/panel_ctrl.sv
// Panel controller: debounced five-button BCD editor with a multiplexed 7-segment display.
// Optional cursor blink is compiled in with the PANEL_BLINK_EN macro.
module panel_ctrl #(
  parameter int NUM_DIGITS      = 8,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SCAN_CYCLES     = 100_000,
  parameter int BLINK_CYCLES    = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    btnL,
  input  logic                    btnD,
  input  logic                    btnU,
  input  logic                    btnR,
  input  logic                    btnC,
  output logic [4*NUM_DIGITS-1:0] num,
  output logic [NUM_DIGITS-1:0]   cursor,
  output logic [6:0]              cathode,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic                    dp
);

  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SCW = $clog2(SCAN_CYCLES + 1);
  localparam int IDW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int NB  = 5;

  // Button bit positions inside the internal vectors.
  localparam int B_R = 0;
  localparam int B_L = 1;
  localparam int B_D = 2;
  localparam int B_U = 3;
  localparam int B_C = 4;

  logic [NB-1:0] raw;
  logic [NB-1:0] sync1;
  logic [NB-1:0] sync2;
  logic [NB-1:0] deb;
  logic [NB-1:0] deb_q;
  logic [NB-1:0] press;
  logic [DBW-1:0] db_cnt [NB];

  logic [NUM_DIGITS-1:0][3:0] digits;
  logic [SCW-1:0]             scan_cnt;
  logic [IDW-1:0]             scan_idx;
  logic [NUM_DIGITS-1:0]      blank_mask;

  assign raw = {btnC, btnU, btnD, btnL, btnR};
  assign num = digits;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // A level is accepted only after it has disagreed with the debounced value for a full window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < NB; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != deb[i]) begin
          if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
            deb[i]    <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_q <= '0;
      press <= '0;
    end else begin
      deb_q <= deb;
      press <= deb & ~deb_q;
    end
  end

  // The priority chain means only one edit is applied when several presses coincide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digits <= '0;
      cursor <= NUM_DIGITS'(1);
    end else if (press[B_C]) begin
      digits <= '0;
      cursor <= NUM_DIGITS'(1);
    end else if (press[B_U]) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (cursor[i]) digits[i] <= (digits[i] == 4'd9) ? 4'd0 : digits[i] + 4'd1;
    end else if (press[B_D]) begin
      for (int i = 0; i < NUM_DIGITS; i++)
        if (cursor[i]) digits[i] <= (digits[i] == 4'd0) ? 4'd9 : digits[i] - 4'd1;
    end else if (press[B_L]) begin
      cursor <= {cursor[NUM_DIGITS-2:0], cursor[NUM_DIGITS-1]};
    end else if (press[B_R]) begin
      cursor <= {cursor[0], cursor[NUM_DIGITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCW'(SCAN_CYCLES - 1)) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == IDW'(NUM_DIGITS - 1)) ? '0 : scan_idx + 1'b1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

`ifdef PANEL_BLINK_EN
  localparam int BKW = $clog2(BLINK_CYCLES + 1);

  logic [BKW-1:0] blink_cnt;
  logic           blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt <= '0;
      blank     <= 1'b0;
    end else if (blink_cnt == BKW'(BLINK_CYCLES - 1)) begin
      blink_cnt <= '0;
      blank     <= ~blank;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  assign blank_mask = blank ? cursor : '0;
`else
  // The blink period has no effect here; the expression folds to a constant zero mask.
  assign blank_mask = {NUM_DIGITS{BLINK_CYCLES < 0}};
`endif

  // Display outputs are registered from the scan index, so they trail it by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      anode   <= '1;
      cathode <= 7'h7F;
      dp      <= 1'b1;
    end else begin
      anode   <= ~(NUM_DIGITS'(1) << scan_idx) | blank_mask;
      cathode <= seg7(digits[scan_idx]);
      dp      <= ~cursor[scan_idx];
    end
  end

endmodule

// File: tb/tb_panel_ctrl.sv
// Directed self-checking bench for panel_ctrl with small debounce/scan parameters.
`timescale 1ns/1ps
module tb_panel_ctrl;

  localparam int ND = 4;
  localparam logic [4:0] BC = 5'b10000;
  localparam logic [4:0] BU = 5'b01000;
  localparam logic [4:0] BD = 5'b00100;
  localparam logic [4:0] BL = 5'b00010;
  localparam logic [4:0] BR = 5'b00001;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btnL = 1'b0, btnD = 1'b0, btnU = 1'b0, btnR = 1'b0, btnC = 1'b0;
  logic [4*ND-1:0] num;
  logic [ND-1:0]   cursor;
  logic [6:0]      cathode;
  logic [ND-1:0]   anode;
  logic            dp;

  int errors = 0;
  int checks = 0;
  int cyc;

  typedef struct {
    logic [4:0]  btn;
    logic [15:0] exp_num;
    logic [3:0]  exp_cur;
  } vec_t;

  vec_t vectors [19];

  panel_ctrl #(
    .NUM_DIGITS(ND),
    .DEBOUNCE_CYCLES(4),
    .SCAN_CYCLES(8),
    .BLINK_CYCLES(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btnL(btnL),
    .btnD(btnD),
    .btnU(btnU),
    .btnR(btnR),
    .btnC(btnC),
    .num(num),
    .cursor(cursor),
    .cathode(cathode),
    .anode(anode),
    .dp(dp)
  );

  always #5 clk = ~clk;

  // Cycles since reset release; edge n after release gives cyc == n.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: seg_of = 7'b1000000;
      1: seg_of = 7'b1111001;
      2: seg_of = 7'b0100100;
      3: seg_of = 7'b0110000;
      4: seg_of = 7'b0011001;
      5: seg_of = 7'b0010010;
      6: seg_of = 7'b0000010;
      7: seg_of = 7'b1111000;
      8: seg_of = 7'b0000000;
      9: seg_of = 7'b0010000;
      default: seg_of = 7'h7F;
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_buttons(input logic [4:0] m);
    {btnC, btnU, btnD, btnL, btnR} = m;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] m);
    set_buttons(m);
    tick(10);
    set_buttons(5'b0);
    tick(12);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int slot;
    int d;
    logic [3:0] ea;

    vectors[0]  = '{BR,      16'h0000, 4'b1000};
    vectors[1]  = '{BD,      16'h9000, 4'b1000};
    vectors[2]  = '{BL,      16'h9000, 4'b0001};
    vectors[3]  = '{BU,      16'h9001, 4'b0001};
    vectors[4]  = '{BU,      16'h9002, 4'b0001};
    vectors[5]  = '{BU,      16'h9003, 4'b0001};
    vectors[6]  = '{BL,      16'h9003, 4'b0010};
    vectors[7]  = '{BU,      16'h9013, 4'b0010};
    vectors[8]  = '{BD,      16'h9003, 4'b0010};
    vectors[9]  = '{BD,      16'h9093, 4'b0010};
    vectors[10] = '{BL,      16'h9093, 4'b0100};
    vectors[11] = '{BL,      16'h9093, 4'b1000};
    vectors[12] = '{BU,      16'h0093, 4'b1000};
    vectors[13] = '{BL,      16'h0093, 4'b0001};
    vectors[14] = '{BR,      16'h0093, 4'b1000};
    vectors[15] = '{BC,      16'h0000, 4'b0001};
    vectors[16] = '{BU|BD,   16'h0001, 4'b0001};
    vectors[17] = '{BD|BL|BR,16'h0000, 4'b0001};
    vectors[18] = '{BL|BR,   16'h0000, 4'b0010};

    set_buttons(5'b0);
    rst_n = 1'b0;
    tick(3);
    checkOutput("reset num", num, 0);
    checkOutput("reset cursor", cursor, 4'b0001);
    checkOutput("reset anode", anode, 4'hF);
    checkOutput("reset cathode", cathode, 7'h7F);
    checkOutput("reset dp", dp, 1'b1);

    // Free-running scan with all digits zero and cursor on digit 0.
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      slot = ((k - 1) / 8) % 4;
      ea = ~(4'b0001 << slot);
      checkOutput($sformatf("scan0 anode k%0d", k), anode, ea);
      checkOutput($sformatf("scan0 cathode k%0d", k), cathode, 7'b1000000);
      checkOutput($sformatf("scan0 dp k%0d", k), dp, (slot == 0) ? 1'b0 : 1'b1);
    end

    // Held button: action lands on edge 8 after the rise, exactly once.
    set_buttons(BU);
    tick(7);
    checkOutput("hold num before pulse", num, 16'h0000);
    tick(1);
    checkOutput("hold num after pulse", num, 16'h0001);
    tick(12);
    set_buttons(5'b0);
    tick(12);
    checkOutput("hold num final", num, 16'h0001);

    // Bouncing input never stays stable long enough.
    for (int i = 0; i < 15; i++) begin
      set_buttons((i % 2 == 0) ? BU : 5'b0);
      tick(2);
    end
    set_buttons(5'b0);
    tick(12);
    checkOutput("bounce num", num, 16'h0001);

    do_reset();
    for (int i = 0; i < 19; i++) begin
      applyStimulus(vectors[i].btn);
      checkOutput($sformatf("vec%0d num", i), num, vectors[i].exp_num);
      checkOutput($sformatf("vec%0d cursor", i), cursor, vectors[i].exp_cur);
    end

    // Build 1234, then press C and U together.
    do_reset();
    repeat (4) applyStimulus(BU);
    applyStimulus(BL);
    repeat (3) applyStimulus(BU);
    applyStimulus(BL);
    repeat (2) applyStimulus(BU);
    applyStimulus(BL);
    applyStimulus(BU);
    checkOutput("build 1234 num", num, 16'h1234);
    checkOutput("build 1234 cursor", cursor, 4'b1000);
    applyStimulus(BC | BU);
    checkOutput("C+U num", num, 16'h0000);
    checkOutput("C+U cursor", cursor, 4'b0001);

    // Build 0907 with cursor back on digit 0, then check the scanned display.
    do_reset();
    repeat (7) applyStimulus(BU);
    applyStimulus(BL);
    applyStimulus(BL);
    repeat (9) applyStimulus(BU);
    applyStimulus(BL);
    applyStimulus(BL);
    checkOutput("build 0907 num", num, 16'h0907);
    checkOutput("build 0907 cursor", cursor, 4'b0001);
    for (int k = 0; k < 32; k++) begin
      tick(1);
      slot = ((cyc - 1) / 8) % 4;
      ea = ~(4'b0001 << slot);
      d = (slot == 0) ? 7 : (slot == 2) ? 9 : 0;
      checkOutput($sformatf("scan0907 anode c%0d", cyc), anode, ea);
      checkOutput($sformatf("scan0907 cathode c%0d", cyc), cathode, seg_of(d));
      checkOutput($sformatf("scan0907 dp c%0d", cyc), dp, (slot == 0) ? 1'b0 : 1'b1);
    end

    // Reset mid-debounce aborts; button held through release gives one timed press.
    set_buttons(BU);
    tick(4);
    rst_n = 1'b0;
    tick(2);
    checkOutput("midreset num", num, 16'h0000);
    checkOutput("midreset anode", anode, 4'hF);
    rst_n = 1'b1;
    tick(7);
    checkOutput("post-reset num before pulse", num, 16'h0000);
    tick(1);
    checkOutput("post-reset num after pulse", num, 16'h0001);
    tick(10);
    set_buttons(5'b0);
    tick(12);
    checkOutput("post-reset num final", num, 16'h0001);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
